// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundle of the requester-side and memory-side signals of dmem_arbiter.
//
// Handshake: a requester raises xReq with its address (and, for D, the access
// type and write data) and holds them stable until it sees xReady high. xReady
// is a one-cycle pulse; xRData and xErr are only meaningful in that cycle. The
// requester drops xReq at the edge after seeing xReady; a request still high
// in the following IDLE cycle starts a new access.
//
// Modports:
//   slave  - the arbiter side (drives ready/rdata/err, memory controls, busy)
//   master - the environment side (requesters and memory model)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;
    // I port
    logic        iReq;
    logic [31:0] iAddr;
    logic        iReady;
    logic [31:0] iRData;
    logic        iErr;
    // D port
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWData;
    logic        dReady;
    logic [31:0] dRData;
    logic        dErr;
    // memory side
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memReadData;
    // status
    logic        busy;

    modport slave (
        input  iReq, iAddr, dReq, dWe, dAddr, dWData, memReadData,
        output iReady, iRData, iErr, dReady, dRData, dErr,
               memAddr, memWriteData, memRead, memWrite, busy
    );

    modport master (
        output iReq, iAddr, dReq, dWe, dAddr, dWData, memReadData,
        input  iReady, iRData, iErr, dReady, dRData, dErr,
               memAddr, memWriteData, memRead, memWrite, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-port arbiter and sequencer in front of a single-port, word-addressed
// data memory. The instruction-fetch port (I) and the load/store port (D)
// share the memory; one access is in flight at a time and its memory-side
// controls are held for LATENCY cycles. Misaligned addresses complete with
// an error without touching memory.
//
// Ports:
//   clock      - system clock, rising edge
//   reset_n    - asynchronous active-low reset
//   bus        - dmem_arbiter_if.slave: I/D request ports, memory port, busy
//   dbg_state  - current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
//   grantCntI, grantCntD, stallCnt - performance counters, present only when
//                the macro DMEM_ARB_PERF_EN is defined
//
// Parameters:
//   LATENCY      - cycles memRead/memWrite are held per access (1..15)
//   MAX_D_STREAK - D grants in a row while I waits before I is forced (1..15)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    dmem_arbiter_if.slave      bus,
`ifdef DMEM_ARB_PERF_EN
    output logic [15:0]        grantCntI,
    output logic [15:0]        grantCntD,
    output logic [15:0]        stallCnt,
`endif
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD   = 4'(LATENCY - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t      state;
    state_t      state_next;

    // latched access
    logic        port_d;       // 1 = current access belongs to D
    logic        we_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [3:0]  cnt;
    logic [3:0]  streak;

    // memory-side registers; only updated for accesses that reach memory so
    // they keep their last driven value across misaligned requests
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    // IDLE-cycle arbitration
    logic        grant_i;
    logic        grant_d;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic        misaligned;

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == ST_IDLE) begin
            if (bus.dReq && bus.iReq) begin
                // D normally wins; a full streak hands the slot to I
                if (streak == STREAK_MAX) grant_i = 1'b1;
                else                      grant_d = 1'b1;
            end else if (bus.dReq) begin
                grant_d = 1'b1;
            end else if (bus.iReq) begin
                grant_i = 1'b1;
            end
        end
    end

    // The I port is read-only, so its write data and type are fixed
    assign sel_addr   = grant_d ? bus.dAddr  : bus.iAddr;
    assign sel_wdata  = grant_d ? bus.dWData : 32'd0;
    assign sel_we     = grant_d & bus.dWe;
    assign misaligned = (sel_addr[1:0] != 2'b00);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (grant_i || grant_d)
                    state_next = misaligned ? ST_DONE : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt == 4'd0) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            port_d      <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            cnt         <= 4'd0;
            streak      <= 4'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            if (grant_i || grant_d) begin
                port_d  <= grant_d;
                we_q    <= sel_we;
                err_q   <= misaligned;
                rdata_q <= 32'd0;   // stays 0 for writes and errors
                cnt     <= CNT_LOAD;
                if (!misaligned) begin
                    mem_addr_q  <= sel_addr;
                    mem_wdata_q <= sel_wdata;
                end
                // streak only grows while I is actually being held off
                if (grant_d && bus.iReq)
                    streak <= (streak == STREAK_MAX) ? streak : streak + 4'd1;
                else
                    streak <= 4'd0;
            end
            if (state == ST_ACCESS) begin
                if (cnt == 4'd0) begin
                    if (!we_q) rdata_q <= bus.memReadData;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

    // Controls derive from the state register, so an asynchronous reset
    // drops them immediately.
    assign bus.memRead      = (state == ST_ACCESS) && !we_q;
    assign bus.memWrite     = (state == ST_ACCESS) &&  we_q;
    assign bus.memAddr      = mem_addr_q;
    assign bus.memWriteData = mem_wdata_q;

    assign bus.iReady = (state == ST_DONE) && !port_d;
    assign bus.dReady = (state == ST_DONE) &&  port_d;
    assign bus.iRData = bus.iReady ? rdata_q : 32'd0;
    assign bus.dRData = bus.dReady ? rdata_q : 32'd0;
    assign bus.iErr   = bus.iReady & err_q;
    assign bus.dErr   = bus.dReady & err_q;

    assign bus.busy   = (state != ST_IDLE);
    assign dbg_state  = state;

`ifdef DMEM_ARB_PERF_EN
    // A port is "being serviced" from its grant through its DONE cycle; a
    // cycle counts as a stall when any raised request is not the one being
    // serviced (this includes the IDLE cycle in which a request is sampled).
    logic i_serviced;
    logic d_serviced;

    assign i_serviced = (state != ST_IDLE) && !port_d;
    assign d_serviced = (state != ST_IDLE) &&  port_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grantCntI <= 16'd0;
            grantCntD <= 16'd0;
            stallCnt  <= 16'd0;
        end else begin
            if (grant_i) grantCntI <= grantCntI + 16'd1;
            if (grant_d) grantCntD <= grantCntD + 16'd1;
            if ((bus.iReq && !i_serviced) || (bus.dReq && !d_serviced))
                stallCnt <= stallCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed self-checking bench for dmem_arbiter with LATENCY=2 and
// MAX_D_STREAK=4. A word-addressed memory model answers memRead
// combinationally and writes on the clock edge while memWrite is high.
// The performance-counter section is compiled only with DMEM_ARB_PERF_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int unsigned LAT = 2;
    localparam int unsigned MDS = 4;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset_n;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    dmem_arbiter_if bus ();
    logic [1:0] dbg_state;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] grantCntI;
    logic [15:0] grantCntD;
    logic [15:0] stallCnt;
`endif

    dmem_arbiter #(.LATENCY(LAT), .MAX_D_STREAK(MDS)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
`ifdef DMEM_ARB_PERF_EN
        .grantCntI (grantCntI),
        .grantCntD (grantCntD),
        .stallCnt  (stallCnt),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [0:255];
    assign bus.memReadData = mem[bus.memAddr[9:2]];
    always @(posedge clock) begin
        if (bus.memWrite) mem[bus.memAddr[9:2]] <= bus.memWriteData;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [0:0] exp_q [$];   // expected grant order, 1 = D, 0 = I

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One access on one port. Reports read data, error flag, number of
    // rising edges from the sampling edge to the one that raised Ready
    // (inclusive), cycles memRead/memWrite were seen high, and the address
    // seen while they were high. Returns one cycle after Ready (FSM in IDLE).
    task automatic do_access(input bit is_d, input bit we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output logic err,
                             output int lat, output int rd_cyc, output int wr_cyc,
                             output logic [31:0] seen_addr);
        bit found;
        found = 1'b0;
        rdata = '0; err = 1'b0; lat = 0; rd_cyc = 0; wr_cyc = 0; seen_addr = '0;
        @(negedge clock);
        if (is_d) begin
            bus.dReq = 1'b1; bus.dWe = we; bus.dAddr = addr; bus.dWData = wdata;
        end else begin
            bus.iReq = 1'b1; bus.iAddr = addr;
        end
        for (int n = 0; n < 64 && !found; n++) begin
            @(posedge clock); #1;
            lat++;
            if (bus.memRead)  rd_cyc++;
            if (bus.memWrite) wr_cyc++;
            if (bus.memRead || bus.memWrite) seen_addr = bus.memAddr;
            if (is_d ? bus.dReady : bus.iReady) begin
                found = 1'b1;
                rdata = is_d ? bus.dRData : bus.iRData;
                err   = is_d ? bus.dErr   : bus.iErr;
            end
        end
        bus.dReq = 1'b0;
        bus.iReq = 1'b0;
        check("ready_seen", {31'd0, found}, 32'd1);
        @(posedge clock); #1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rd;
    logic        er;
    int          lat, rdc, wrc;
    logic [31:0] sa;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[1] = 32'h0000_0124;
        bus.iReq = 1'b0; bus.iAddr = '0;
        bus.dReq = 1'b0; bus.dWe = 1'b0; bus.dAddr = '0; bus.dWData = '0;
        reset_n = 1'b0;
        #1;
        // reset state
        check("rst_busy",    {31'd0, bus.busy},     32'd0);
        check("rst_memread", {31'd0, bus.memRead},  32'd0);
        check("rst_memwr",   {31'd0, bus.memWrite}, 32'd0);
        check("rst_dready",  {31'd0, bus.dReady},   32'd0);
        check("rst_iready",  {31'd0, bus.iReady},   32'd0);
        check("rst_memaddr", bus.memAddr,           32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // D read of word 0x4
        do_access(1'b1, 1'b0, 32'h4, 32'h0, rd, er, lat, rdc, wrc, sa);
        check("dread_data",  rd,               32'h124);
        check("dread_err",   {31'd0, er},      32'd0);
        check("dread_lat",   32'(lat),         32'(LAT + 1));
        check("dread_rdcyc", 32'(rdc),         32'(LAT));
        check("dread_wrcyc", 32'(wrc),         32'd0);
        check("dread_addr",  sa,               32'h4);

        // D write 0x8, then I read it back
        do_access(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, rd, er, lat, rdc, wrc, sa);
        check("dwrite_data",  rd,              32'd0);
        check("dwrite_wrcyc", 32'(wrc),        32'(LAT));
        check("dwrite_rdcyc", 32'(rdc),        32'd0);
        check("dwrite_addr",  sa,              32'h8);
        check("dwrite_mem",   mem[2],          32'hDEAD_BEEF);
        do_access(1'b0, 1'b0, 32'h8, 32'h0, rd, er, lat, rdc, wrc, sa);
        check("iread_data",  rd,               32'hDEAD_BEEF);
        check("iread_err",   {31'd0, er},      32'd0);
        check("iread_lat",   32'(lat),         32'(LAT + 1));

        // misaligned D read: no memory access, immediate error completion
        do_access(1'b1, 1'b0, 32'h6, 32'h0, rd, er, lat, rdc, wrc, sa);
        check("mis_err",     {31'd0, er},      32'd1);
        check("mis_data",    rd,               32'd0);
        check("mis_lat",     32'(lat),         32'd1);
        check("mis_rdcyc",   32'(rdc),         32'd0);
        check("mis_wrcyc",   32'(wrc),         32'd0);
        check("mis_addr_hold", bus.memAddr,    32'h8);

        // both ports requesting continuously: D x4 then I, repeating
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < int'(MDS); j++) exp_q.push_back(1'b1);
            exp_q.push_back(1'b0);
        end
        begin
            int got_n;
            got_n = 0;
            @(negedge clock);
            bus.iReq = 1'b1; bus.iAddr = 32'h4;
            bus.dReq = 1'b1; bus.dWe = 1'b0; bus.dAddr = 32'h8;
            for (int n = 0; n < 200 && got_n < 10; n++) begin
                @(posedge clock); #1;
                if (bus.iReady && bus.dReady)
                    check("both_ready", 32'd1, 32'd0);
                if (bus.iReady || bus.dReady) begin
                    logic [0:0] e;
                    e = exp_q.pop_front();
                    check($sformatf("grant_%0d", got_n), {31'd0, bus.dReady}, {31'd0, e});
                    check($sformatf("grant_data_%0d", got_n),
                          bus.dReady ? bus.dRData : bus.iRData,
                          bus.dReady ? 32'hDEAD_BEEF : 32'h124);
                    got_n++;
                end
            end
            bus.iReq = 1'b0;
            bus.dReq = 1'b0;
            check("streak_count", 32'(got_n), 32'd10);
            @(posedge clock); #1;
        end

        // asynchronous reset in the second ACCESS cycle of a write
        @(negedge clock);
        bus.dReq = 1'b1; bus.dWe = 1'b1; bus.dAddr = 32'h10; bus.dWData = 32'h5555_AAAA;
        @(posedge clock); #1;
        check("abort_wr1", {31'd0, bus.memWrite}, 32'd1);
        @(posedge clock); #1;
        check("abort_wr2", {31'd0, bus.memWrite}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_memwr",  {31'd0, bus.memWrite}, 32'd0);
        check("abort_busy",   {31'd0, bus.busy},     32'd0);
        check("abort_dready", {31'd0, bus.dReady},   32'd0);
        bus.dReq = 1'b0;
        begin
            int rdy_seen;
            rdy_seen = 0;
            repeat (3) begin
                @(posedge clock); #1;
                if (bus.dReady || bus.iReady) rdy_seen++;
            end
            @(negedge clock);
            reset_n = 1'b1;
            repeat (LAT + 2) begin
                @(posedge clock); #1;
                if (bus.dReady || bus.iReady) rdy_seen++;
            end
            check("abort_noready", 32'(rdy_seen), 32'd0);
        end
        do_access(1'b1, 1'b0, 32'h4, 32'h0, rd, er, lat, rdc, wrc, sa);
        check("post_rst_data", rd,       32'h124);
        check("post_rst_lat",  32'(lat), 32'(LAT + 1));

`ifdef DMEM_ARB_PERF_EN
        // 2 lone I reads, 4 lone D reads, then one I+D pair.
        // Each lone access waits one IDLE cycle; the pair adds 1 (IDLE) +
        // LAT (D access) + 1 (D DONE) + 1 (next IDLE) = LAT+3.
        apply_reset();
        check("perf_rst_i", {16'd0, grantCntI}, 32'd0);
        check("perf_rst_s", {16'd0, stallCnt},  32'd0);
        for (int j = 0; j < 2; j++)
            do_access(1'b0, 1'b0, 32'h4, 32'h0, rd, er, lat, rdc, wrc, sa);
        for (int j = 0; j < 4; j++)
            do_access(1'b1, 1'b0, 32'h8, 32'h0, rd, er, lat, rdc, wrc, sa);
        begin
            bit i_done, d_done;
            i_done = 1'b0; d_done = 1'b0;
            @(negedge clock);
            bus.iReq = 1'b1; bus.iAddr = 32'h4;
            bus.dReq = 1'b1; bus.dWe = 1'b0; bus.dAddr = 32'h8;
            for (int n = 0; n < 64 && !(i_done && d_done); n++) begin
                @(posedge clock); #1;
                if (bus.iReady) begin i_done = 1'b1; bus.iReq = 1'b0; end
                if (bus.dReady) begin d_done = 1'b1; bus.dReq = 1'b0; end
            end
            bus.iReq = 1'b0; bus.dReq = 1'b0;
            check("perf_pair_done", {30'd0, i_done, d_done}, 32'd3);
            @(posedge clock); #1;
        end
        check("perf_grant_i", {16'd0, grantCntI}, 32'd3);
        check("perf_grant_d", {16'd0, grantCntD}, 32'd5);
        check("perf_stall",   {16'd0, stallCnt},  32'(6 + LAT + 3));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "time limit reached");
    end

endmodule
